// File: rtl/piradip_sysref_tracker.sv
// SYSREF period tracker: detects synchronized SYSREF rising edges, qualifies
// the period over LOCK_COUNT consecutive intervals, then runs a free-running
// phase counter with a once-per-period sync_pulse. Supports armed phase
// re-alignment and counts loss-of-lock events (saturating).
module piradip_sysref_tracker #(
    parameter int PERIOD_W   = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic                adc_clk,
    input  logic                resetn,
    input  logic                sysref,
    input  logic                enable,
    input  logic                arm,
    output logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] phase,
    output logic                sync_pulse,
    output logic                locked,
    output logic                armed,
    output logic                aligned_pulse,
    output logic [7:0]          err_count,
    output logic [1:0]          state
);

    localparam int W1 = PERIOD_W + 1;
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              cur_state, next_state;
    logic                sysref_d;
    logic [PERIOD_W-1:0] icnt, icnt_n;
    logic                ref_valid, ref_valid_n;
    logic [PERIOD_W-1:0] cand, cand_n;
    logic [MW-1:0]       match, match_n;
    logic [PERIOD_W-1:0] period_n, phase_n;
    logic                sync_n, locked_n, armed_n, aligned_n;
    logic [7:0]          err_n;

    logic                rise;
    logic                icnt_sat;
    logic [W1-1:0]       icnt_x, cand_x, period_x, tol_x, lim_x;
    logic [W1-1:0]       diff_cand, diff_period;
    logic                in_tol_cand, in_tol_period;
    logic                loss;

    assign rise     = sysref & ~sysref_d;
    assign icnt_sat = &icnt;
    assign state    = cur_state;

    // Extended-width deviation measurements so period+TOL never wraps
    always_comb begin
        icnt_x      = {1'b0, icnt};
        cand_x      = {1'b0, cand};
        period_x    = {1'b0, period};
        tol_x       = W1'(TOL);
        lim_x       = period_x + tol_x;
        diff_cand   = (icnt_x >= cand_x)   ? (icnt_x - cand_x)   : (cand_x - icnt_x);
        diff_period = (icnt_x >= period_x) ? (icnt_x - period_x) : (period_x - icnt_x);
        in_tol_cand   = (diff_cand <= tol_x);
        in_tol_period = (diff_period <= tol_x);
    end

    // Next-state and next-output computation for the tracker
    always_comb begin
        next_state  = cur_state;
        icnt_n      = rise ? PERIOD_W'(1) : (icnt_sat ? icnt : icnt + PERIOD_W'(1));
        ref_valid_n = ref_valid;
        cand_n      = cand;
        match_n     = match;
        period_n    = period;
        phase_n     = phase;
        armed_n     = armed;
        aligned_n   = 1'b0;
        err_n       = err_count;
        loss        = 1'b0;

        if (!enable) begin
            next_state = IDLE;
            phase_n    = '0;
            armed_n    = 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    phase_n    = '0;
                    armed_n    = 1'b0;
                    next_state = ACQUIRE;
                end
                ACQUIRE: begin
                    phase_n = '0;
                    armed_n = 1'b0;
                    if (rise && ref_valid) begin
                        if (in_tol_cand && (match != '0)) begin
                            match_n = match + MW'(1);
                        end else begin
                            cand_n  = icnt;
                            match_n = MW'(1);
                        end
                        if (match_n == MW'(LOCK_COUNT)) begin
                            next_state = LOCKED;
                            period_n   = cand_n;
                            phase_n    = '0;
                        end
                    end
                end
                LOCKED: begin
                    phase_n = (({1'b0, phase} + W1'(1)) >= period_x) ? '0 : phase + PERIOD_W'(1);
                    loss    = rise ? !in_tol_period : (icnt_x >= lim_x);
                    if (loss) begin
                        next_state = ACQUIRE;
                        armed_n    = 1'b0;
                        match_n    = '0;
                        if (err_count != 8'hFF) begin
                            err_n = err_count + 8'd1;
                        end
                    end else begin
                        // An arm in the same cycle as the rise re-arms and defers capture
                        if (armed && rise && !arm) begin
                            phase_n   = '0;
                            aligned_n = 1'b1;
                            armed_n   = 1'b0;
                        end
                        if (arm) begin
                            armed_n = 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = IDLE;
                    phase_n    = '0;
                    armed_n    = 1'b0;
                end
            endcase
        end

        if ((next_state == ACQUIRE) && (cur_state != ACQUIRE)) begin
            ref_valid_n = 1'b0;
            match_n     = '0;
        end else if (rise) begin
            ref_valid_n = 1'b1;
        end else if (icnt_sat) begin
            ref_valid_n = 1'b0;
        end

        locked_n = (next_state == LOCKED);
        sync_n   = (next_state == LOCKED) && (phase_n == '0);
    end

    // State and registered outputs
    always_ff @(posedge adc_clk or negedge resetn) begin
        if (!resetn) begin
            cur_state     <= IDLE;
            sysref_d      <= 1'b0;
            icnt          <= '0;
            ref_valid     <= 1'b0;
            cand          <= '0;
            match         <= '0;
            period        <= '0;
            phase         <= '0;
            sync_pulse    <= 1'b0;
            locked        <= 1'b0;
            armed         <= 1'b0;
            aligned_pulse <= 1'b0;
            err_count     <= '0;
        end else begin
            cur_state     <= next_state;
            sysref_d      <= sysref;
            icnt          <= icnt_n;
            ref_valid     <= ref_valid_n;
            cand          <= cand_n;
            match         <= match_n;
            period        <= period_n;
            phase         <= phase_n;
            sync_pulse    <= sync_n;
            locked        <= locked_n;
            armed         <= armed_n;
            aligned_pulse <= aligned_n;
            err_count     <= err_n;
        end
    end

endmodule

// File: tb/tb_piradip_sysref_tracker.sv
// Directed bench for piradip_sysref_tracker: table of per-rise vectors for
// tolerance/arm/loss behaviour plus hand sequences for reset, missing edge,
// error saturation and enable drop.
module tb_piradip_sysref_tracker;

    logic        adc_clk = 1'b0;
    logic        resetn;
    logic        sysref;
    logic        enable;
    logic        arm;
    logic [15:0] period;
    logic [15:0] phase;
    logic        sync_pulse;
    logic        locked;
    logic        armed;
    logic        aligned_pulse;
    logic [7:0]  err_count;
    logic [1:0]  state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ep        = 0;
    bit track     = 0;

    localparam int S_IDLE = 0;
    localparam int S_ACQ  = 1;
    localparam int S_LOCK = 2;

    typedef struct {
        int   p;
        logic arm_at_rise;
        int   st;
        int   err;
        logic armed_exp;
        logic al_exp;
    } vec_t;

    vec_t tbl [13];

    piradip_sysref_tracker #(.PERIOD_W(16), .LOCK_COUNT(4), .TOL(1)) dut (
        .adc_clk       (adc_clk),
        .resetn        (resetn),
        .sysref        (sysref),
        .enable        (enable),
        .arm           (arm),
        .period        (period),
        .phase         (phase),
        .sync_pulse    (sync_pulse),
        .locked        (locked),
        .armed         (armed),
        .aligned_pulse (aligned_pulse),
        .err_count     (err_count),
        .state         (state)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // drive one cycle of inputs, return 1 time unit after the capturing edge
    task automatic tick(input logic s, input logic a);
        sysref = s;
        arm    = a;
        @(posedge adc_clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic chk_phase();
        if (track) begin
            chk("phase", phase, ep);
            chk("sync_pulse", sync_pulse, (ep == 0) ? 1 : 0);
        end
    endtask

    // P-1 non-rise cycles following a rise; SYSREF high width is 4
    task automatic gap(input int p);
        for (int i = 1; i < p; i++) begin
            tick((i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (track) ep = (ep + 1) % 16;
            chk_phase();
        end
    endtask

    // from ACQUIRE with SYSREF low: reference rise + LOCK_COUNT qualifying rises
    task automatic acquire(input int p);
        track = 0;
        tick(1'b1, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            gap(p);
            chk("acq_pre_rise_locked", locked, 0);
            tick(1'b1, 1'b0);
            chk("acq_locked", locked, (k == 5) ? 1 : 0);
        end
        ep    = 0;
        track = 1;
        chk_phase();
    endtask

    initial begin
        tbl[0]  = '{15, 1'b0, S_LOCK, 0, 1'b0, 1'b0};
        tbl[1]  = '{16, 1'b1, S_LOCK, 0, 1'b1, 1'b0};
        tbl[2]  = '{16, 1'b0, S_LOCK, 0, 1'b0, 1'b1};
        tbl[3]  = '{17, 1'b0, S_LOCK, 0, 1'b0, 1'b0};
        tbl[4]  = '{16, 1'b1, S_LOCK, 0, 1'b1, 1'b0};
        tbl[5]  = '{16, 1'b0, S_LOCK, 0, 1'b0, 1'b1};
        tbl[6]  = '{16, 1'b1, S_LOCK, 0, 1'b1, 1'b0};
        tbl[7]  = '{14, 1'b0, S_ACQ,  1, 1'b0, 1'b0};
        tbl[8]  = '{16, 1'b1, S_ACQ,  1, 1'b0, 1'b0};
        tbl[9]  = '{16, 1'b0, S_ACQ,  1, 1'b0, 1'b0};
        tbl[10] = '{16, 1'b0, S_ACQ,  1, 1'b0, 1'b0};
        tbl[11] = '{16, 1'b0, S_ACQ,  1, 1'b0, 1'b0};
        tbl[12] = '{16, 1'b0, S_LOCK, 1, 1'b0, 1'b0};

        resetn = 1'b0;
        sysref = 1'b0;
        enable = 1'b0;
        arm    = 1'b0;
        #22;
        chk("por_state", state, S_IDLE);
        chk("por_period", period, 0);
        chk("por_err", err_count, 0);
        chk("por_locked", locked, 0);
        @(negedge adc_clk);
        resetn = 1'b1;
        tick(1'b0, 1'b0);
        chk("idle_disabled", state, S_IDLE);

        // acquisition at period 16
        enable = 1'b1;
        tick(1'b0, 1'b0);
        chk("enter_acquire", state, S_ACQ);
        acquire(16);
        chk("acq_state", state, S_LOCK);
        chk("acq_period", period, 16);
        chk("acq_err", err_count, 0);

        // per-rise vectors: tolerance, arm capture, loss, relock
        for (int r = 0; r < 13; r++) begin
            gap(tbl[r].p);
            tick(1'b1, tbl[r].arm_at_rise);
            if (tbl[r].st == S_LOCK) begin
                ep    = (track && !tbl[r].al_exp) ? (ep + 1) % 16 : 0;
                track = 1;
            end else begin
                track = 0;
            end
            chk($sformatf("vec%0d_state", r), state, tbl[r].st);
            chk($sformatf("vec%0d_err", r), err_count, tbl[r].err);
            chk($sformatf("vec%0d_armed", r), armed, tbl[r].armed_exp);
            chk($sformatf("vec%0d_aligned", r), aligned_pulse, tbl[r].al_exp);
            chk_phase();
        end
        chk("relock_period", period, 16);

        // missing edge: loss detected in the cycle where icnt reaches 17
        track = 0;
        for (int i = 1; i <= 17; i++) begin
            tick((i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (i == 16) chk("miss_still_locked", state, S_LOCK);
        end
        chk("miss_state", state, S_ACQ);
        chk("miss_err", err_count, 2);
        chk("miss_locked", locked, 0);

        // one more loss at period 5, then lock with err_count=3 and reset
        acquire(5);
        chk("p5_period", period, 5);
        track = 0;
        for (int i = 1; i <= 6; i++) tick((i < 4) ? 1'b1 : 1'b0, 1'b0);
        chk("p5_loss_state", state, S_ACQ);
        chk("p5_loss_err", err_count, 3);
        acquire(5);
        track = 0;
        chk("pre_reset_locked", locked, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_state", state, S_IDLE);
        chk("rst_locked", locked, 0);
        chk("rst_period", period, 0);
        chk("rst_phase", phase, 0);
        chk("rst_err", err_count, 0);
        chk("rst_armed", armed, 0);
        chk("rst_aligned", aligned_pulse, 0);
        chk("rst_sync", sync_pulse, 0);
        enable = 1'b0;
        sysref = 1'b0;
        @(negedge adc_clk);
        resetn = 1'b1;
        tick(1'b0, 1'b0);
        chk("rst_release_idle", state, S_IDLE);

        // 300 losses: error counter saturates
        enable = 1'b1;
        tick(1'b0, 1'b0);
        chk("sat_enter_acq", state, S_ACQ);
        for (int n = 0; n < 300; n++) begin
            acquire(5);
            track = 0;
            for (int i = 1; i <= 6; i++) tick((i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (n == 0) chk("sat_first_err", err_count, 1);
        end
        chk("sat_err", err_count, 255);
        chk("sat_state", state, S_ACQ);

        // enable drop while locked and armed
        acquire(16);
        track = 0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("arm_gap_armed", armed, 1);
        enable = 1'b0;
        tick(1'b1, 1'b0);
        chk("dis_state", state, S_IDLE);
        chk("dis_armed", armed, 0);
        chk("dis_locked", locked, 0);
        chk("dis_period", period, 16);
        chk("dis_phase", phase, 0);
        chk("dis_sync", sync_pulse, 0);
        chk("dis_err", err_count, 255);
        tick(1'b0, 1'b0);
        enable = 1'b1;
        tick(1'b0, 1'b0);
        chk("reenable_state", state, S_ACQ);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/piradip_sysref_tracker.md
# piradip_sysref_tracker

Downstream consumer of the MTS clocking block's synchronized `sysref_adc`/`sysref_dac` output; one instance per converter clock domain. Detects SYSREF rising edges, measures and qualifies the SYSREF period, and once locked runs a free-running phase counter with a one-cycle `sync_pulse` per SYSREF period. Supports an armed re-alignment capture for multi-tile sync, and counts loss-of-lock events.

## Interface
- `PERIOD_W`, default 16: width of the period, interval and phase counters.
- `LOCK_COUNT`, default 4: number of consecutive in-tolerance intervals required to lock.
- `TOL`, default 1: allowed interval deviation from the locked period, in cycles.
- `adc_clk` in 1: the single clock (converter domain).
- `resetn` in 1: reset, asynchronous and active-low.
- `sysref` in 1: SYSREF, already synchronized to `adc_clk`.
- `enable` in 1: 0 forces IDLE.
- `arm` in 1: single-cycle request for re-alignment on the next edge.
- `period` out `PERIOD_W`: locked period in cycles.
- `phase` out `PERIOD_W`: 0..`period`-1 while locked.
- `sync_pulse` out 1: high for one cycle when `phase`==0 and LOCKED.
- `locked` out 1: state==LOCKED.
- `armed` out 1: arm pending.
- `aligned_pulse` out 1: one cycle, armed capture done.
- `err_count` out 8: loss-of-lock count, saturating.
- `state` out 2: IDLE=0, ACQUIRE=1, LOCKED=2.

## Operation
- `rise` = `sysref` & ~`sysref_d`. `sysref_d` is a register, reset to 0.
- Interval counter `icnt`:
  - loads 1 on the cycle after a `rise`, otherwise increments, saturating at all-ones.
  - The measured interval at a rise is `icnt`, so rises at T and T+P give P.
  - `ref_valid` is set by the first rise after entering ACQUIRE; it is cleared on entering ACQUIRE or on `icnt` saturation.
- IDLE:
  - Entered when `enable`=0.
  - `phase`, `sync_pulse`, `armed`, `aligned_pulse` and `locked` are 0.
  - `period` and `err_count` hold.
  - `enable`=1 moves to ACQUIRE.
- ACQUIRE, on each `rise` with `ref_valid`:
  - If |`icnt` − `cand`| ≤ `TOL` and `match`>0, then `match`++.
  - Otherwise `cand`=`icnt` and `match`=1.
  - When `match` reaches `LOCK_COUNT`, go to LOCKED with `period`=`cand` and `phase`=0.
- LOCKED:
  - `phase` increments and wraps from `period`−1 to 0.
  - Loss of lock occurs on either of:
    - `rise` with |`icnt` − `period`| > `TOL`;
    - no `rise` while `icnt` ≥ `period`+`TOL`.
  - On loss: go to ACQUIRE, `err_count`++ (saturating at 255), `armed` cleared, `match`=0.
  - In-tolerance rises do not move `phase`; drift is only corrected by arm.
- Arm:
  - `arm` while LOCKED sets `armed`. `arm` in other states is ignored.
  - The next qualifying `rise`, not one in the same cycle as `arm`, forces `phase`=0 on the following cycle, pulses `aligned_pulse`, and clears `armed`.
  - A `rise` that causes loss of lock never produces `aligned_pulse`.
- Width: comparisons use `PERIOD_W`+1 bits, so `period`+`TOL` does not wrap.

## Timing
- Reset values: every output and internal register is 0, and `state`=IDLE.
- All outputs are registered. For a rise detected in cycle T:
  - the state change, `phase`=0, `sync_pulse`, and `aligned_pulse` appear in cycle T+1.
- Lock latency: 1 cycle after the (`LOCK_COUNT`+1)-th rise following ACQUIRE entry.
- Missing edge: the state is ACQUIRE in the cycle after `icnt` = `period`+`TOL` with no rise.
- Deasserting `enable` goes to IDLE the next cycle from any state. Mid-operation `resetn` takes effect immediately.
- A rise and `arm` in the same cycle: the arm registers, and the capture waits for the next rise.

## Test plan
- Reset: assert `resetn`=0 mid-LOCKED with `err_count`=3 -> all outputs 0 immediately; `state`=IDLE after release with `enable`=0.
- Acquire: `enable`=1, SYSREF period 16 with high width 4 -> `locked`=1 exactly 1 cycle after the 5th rise; `period`=16; `sync_pulse` every 16 cycles at `phase`=0; `err_count`=0.
- Tolerance: while locked, intervals of 15 then 17 -> stays locked. Then an interval of 14 -> ACQUIRE next cycle, `err_count`=1, relocks after 5 further good rises.
- Missing edge: locked at 16, drop one pulse -> `state`=ACQUIRE the cycle after `icnt`=17; `err_count` increments by 1. Drive 300 losses -> `err_count` holds at 255.
- Arm: locked at 16, shift SYSREF by +1 (interval 17), pulse `arm` -> `armed`=1. On the next rise at T: `aligned_pulse`=1 and `phase`=0 at T+1, `armed`=0. An `arm` pulse in ACQUIRE -> `armed` stays 0.
- Enable drop: `enable`=0 while armed and locked -> IDLE next cycle, `armed`=0, `period`=16 held. Re-enable -> ACQUIRE.
